// File: rtl/rf_stream_loader.sv
// Stream-to-register-file loader: on go, writes 32 streamed bytes to addresses
// 0..DEPTH-1 through a registered write port and reports their byte sum.
module rf_stream_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int CHK_W  = 13
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              go,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              W_en,
  output logic [ADDR_W-1:0] W_addr,
  output logic [DATA_W-1:0] W_data,
  output logic              done,
  output logic [CHK_W-1:0]  chk,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] DONE_S = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              done_q, done_d;
  logic [CHK_W-1:0]  chk_q, chk_d;
  logic              accept;
  logic              last;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on the state register, never on in_valid.
  assign in_ready = (state_q == LOAD);
  assign accept   = in_valid && in_ready;
  assign last     = (idx_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    w_en_d   = accept;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    done_d   = 1'b0;
    chk_d    = chk_q;
    if (accept) begin
      w_addr_d = idx_q;
      w_data_d = in_data;
      idx_d    = idx_q + ADDR_W'(1);
      chk_d    = chk_q + {{(CHK_W-DATA_W){1'b0}}, in_data};
    end
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = LOAD;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      LOAD: begin
        if (accept && last) begin
          state_d = DONE_S;
          done_d  = 1'b1;
        end
      end
      DONE_S:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      done_q   <= 1'b0;
      chk_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      done_q   <= done_d;
      chk_q    <= chk_d;
    end
  end

  assign W_en      = w_en_q;
  assign W_addr    = w_addr_q;
  assign W_data    = w_data_q;
  assign done      = done_q;
  assign chk       = chk_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rf_stream_loader.sv
// Self-checking bench for rf_stream_loader: table-driven first cycles plus
// full-run sequences checked against an expected-write queue.
module tb_rf_stream_loader;

  logic        Clk, Rst, go, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, W_en, done;
  logic [4:0]  W_addr;
  logic [7:0]  W_data;
  logic [12:0] chk;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  bit mon_en = 0;
  logic [12:0] exp_q[$];
  logic [7:0]  buf_b[32];

  typedef struct {
    logic        go, vld;
    logic [7:0]  din;
    logic        rdy, wen;
    logic [4:0]  addr;
    logic [7:0]  wdat;
    logic        dn;
    logic [12:0] ck;
  } vec_t;
  vec_t tbl[6];

  rf_stream_loader dut (
    .Clk(Clk), .Rst(Rst), .go(go), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .W_en(W_en), .W_addr(W_addr), .W_data(W_data),
    .done(done), .chk(chk), .dbg_state(dbg_state)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Write monitor: every W_en cycle must match the next expected {addr,data}.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (W_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_write actual=addr%0d required=no_write", W_addr);
        end else begin
          check("write_addr_data", {19'd0, W_addr, W_data}, {19'd0, exp_q.pop_front()});
        end
      end
      if (done) begin
        done_cnt++;
        check("done_with_wen", W_en, 1);
        check("done_addr", W_addr, 31);
      end
    end
  end

  task automatic do_run(input int gap_mode, input bit go_hold, input int exp_sum);
    int k, cyc, d0;
    bit v;
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), buf_b[i]});
    go = 1;
    in_valid = 0;
    step();
    if (!go_hold) go = 0;
    check("start_ready", in_ready, 1);
    check("start_chk", chk, 0);
    k = 0;
    cyc = 0;
    while (k < 32 && cyc < 400) begin
      v = (gap_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid = v;
      in_data = v ? buf_b[k] : 8'h3C;
      step();
      if (v) k++;
      cyc++;
    end
    in_valid = go_hold;
    in_data = 8'h77;
    check("run_complete", k, 32);
    if (gap_mode == 0) check("b2b_cycles", cyc, 32);
    check("done_pulse", done, 1);
    check("final_chk", chk, exp_sum);
    check("done_state", dbg_state, 2);
    check("done_ready", in_ready, 0);
    step();
    check("done_low", done, 0);
    check("idle_ready", in_ready, 0);
    check("hold_chk", chk, exp_sum);
    check("idle_state", dbg_state, 0);
    @(negedge Clk);
    #1;
    check("writes_drained", exp_q.size(), 0);
    check("one_done", done_cnt - d0, 1);
  endtask

  initial begin
    Rst = 0; go = 0; in_valid = 0; in_data = 0;

    repeat (4) begin
      go = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom_range(0, 255));
      step();
      check("rst_ready", in_ready, 0);
      check("rst_wen", W_en, 0);
      check("rst_addr", W_addr, 0);
      check("rst_wdata", W_data, 0);
      check("rst_done", done, 0);
      check("rst_chk", chk, 0);
      check("rst_state", dbg_state, 0);
    end
    go = 0; in_valid = 0; in_data = 0;
    Rst = 1;

    //          go vld din    rdy wen addr wdat   dn ck
    tbl[0] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 13'd0};
    tbl[1] = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 13'd0};
    tbl[2] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 5'd0, 8'h03, 1'b0, 13'd3};
    tbl[3] = '{1'b0, 1'b0, 8'h09, 1'b1, 1'b0, 5'd0, 8'h03, 1'b0, 13'd3};
    tbl[4] = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 5'd1, 8'h07, 1'b0, 13'd10};
    tbl[5] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 5'd2, 8'hFF, 1'b0, 13'd265};
    for (int i = 0; i < 6; i++) begin
      go = tbl[i].go;
      in_valid = tbl[i].vld;
      in_data = tbl[i].din;
      step();
      check("tbl_ready", in_ready, tbl[i].rdy);
      check("tbl_wen", W_en, tbl[i].wen);
      check("tbl_addr", W_addr, tbl[i].addr);
      check("tbl_wdata", W_data, tbl[i].wdat);
      check("tbl_done", done, tbl[i].dn);
      check("tbl_chk", chk, tbl[i].ck);
    end

    Rst = 0;
    #1;
    check("abort_ready", in_ready, 0);
    check("abort_wen", W_en, 0);
    check("abort_chk", chk, 0);
    step();
    Rst = 1; go = 0; in_valid = 0;

    mon_en = 1;
    for (int i = 0; i < 32; i++) buf_b[i] = 8'(i);
    do_run(0, 0, 496);

    for (int i = 0; i < 32; i++) buf_b[i] = 8'hFF;
    do_run(1, 0, 8160);

    for (int i = 0; i < 32; i++) buf_b[i] = 8'(3 * i);
    do_run(0, 1, 1488);
    for (int i = 0; i < 32; i++) buf_b[i] = 8'd1;
    do_run(1, 0, 32);

    for (int i = 0; i < 10; i++) exp_q.push_back({5'(i), 8'(100 + i)});
    go = 1;
    step();
    go = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      in_data = 8'(100 + i);
      step();
    end
    @(negedge Clk);
    #1;
    Rst = 0;
    #1;
    check("midrst_wen", W_en, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_state", dbg_state, 0);
    check("midrst_chk", chk, 0);
    check("midrst_writes", exp_q.size(), 0);
    step();
    Rst = 1; in_valid = 0;
    for (int i = 0; i < 32; i++) buf_b[i] = 8'hA5;
    do_run(0, 0, 5280);

    for (int i = 0; i < 32; i++) buf_b[i] = (i % 2 == 0) ? 8'd0 : 8'd10;
    do_run(1, 0, 160);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/rf_stream_loader.md
# rf_stream_loader

Writer side of the 32x8 register file consumed by the sum-of-absolute-differences datapath. On `go`, accepts exactly 32 bytes over a valid/ready stream and writes them to register-file addresses 0..31 through the file's write port. It then pulses `done` and reports a 13-bit byte checksum for cross-checking against the reader's result. It sits between the test/data source and the register file's write port (`W_addr`, `W_en`, `W_data`).

## Interface
- `DEPTH`, 32: number of entries loaded per run; equals the register-file depth.
- `ADDR_W`, 5: write-address width; `2**ADDR_W == DEPTH`.
- `DATA_W`, 8: data width.
- `CHK_W`, 13: checksum width; sized so `DEPTH*(2**DATA_W-1)` cannot overflow.

Ports:
- `Clk`, in, 1: single clock; all state updates on rising edge.
- `Rst`, in, 1: asynchronous, active-low reset.
- `go`, in, 1: start request; level-sampled in IDLE only.
- `in_valid`, in, 1: source has a byte on `in_data`.
- `in_data`, in, DATA_W: stream byte.
- `in_ready`, out, 1: loader accepts a byte this cycle.
- `W_en`, out, 1: register-file write enable, registered.
- `W_addr`, out, ADDR_W: register-file write address, registered.
- `W_data`, out, DATA_W: register-file write data, registered.
- `done`, out, 1: one-cycle completion pulse, registered.
- `chk`, out, CHK_W: unsigned sum of bytes accepted in the current or last run.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE, `go`=1 -> LOAD. On this transition, clear index and `chk` to 0.
  - IDLE, `go`=0 -> IDLE.
  - LOAD, 32nd byte accepted -> DONE.
  - LOAD otherwise -> LOAD.
  - DONE -> IDLE, unconditionally.
- `in_ready` = (state == LOAD). It is decoded combinationally from the state register and never depends on `in_valid`.
- A byte is accepted when `in_valid && in_ready` at a rising edge. On acceptance, the next cycle has:
  - `W_en`=1
  - `W_addr`=index
  - `W_data`=`in_data`
  - index incremented
  - `chk` += zero-extended `in_data`
- `W_en`=0 in every cycle not following an acceptance. `W_addr`/`W_data` hold their last value when `W_en`=0.
- Index is ADDR_W bits and counts 0..31. The acceptance at index 31 is the last one; the index wraps to 0 with no 33rd write.
- `go` is ignored in LOAD and DONE. If `go` is still high when IDLE is re-entered, a new run starts.
- `chk` is cleared only at run start or reset. It holds its final value through DONE and IDLE.
- Arithmetic is unsigned and exact: `chk` max = 32*255 = 8160, which fits in 13 bits.
- `in_valid` gaps are allowed at any point. The loader waits indefinitely with `in_ready`=1, and there is no timeout.

## Timing
- Reset values, applied immediately on `Rst`=0:
  - state = IDLE
  - index = 0
  - `in_ready`=0, `W_en`=0, `W_addr`=0, `W_data`=0, `done`=0, `chk`=0
- Reset mid-LOAD aborts the run:
  - No further writes occur and `in_ready` falls asynchronously.
  - Entries already written stay in the file.
  - After reset deasserts, the loader is in IDLE.
- Start latency: `go` sampled high at edge E0 -> `in_ready`=1 from E0 until the 32nd acceptance.
- Write latency: exactly one cycle from acceptance edge to the cycle in which `W_en` is high.
- `done` is high for exactly one cycle: the cycle after the 32nd acceptance, coincident with the write to address 31. `chk` is final in that same cycle.
- Back-to-back: with `in_valid` held high, 32 acceptances occur on 32 consecutive edges. The minimum run is 34 cycles from `go` sampled to returning to IDLE.
- Simultaneous events:
  - `go` high at the DONE cycle: no effect. If still high, it is sampled in the following IDLE cycle.
  - `in_valid` high in IDLE or DONE: not accepted, because `in_ready`=0.

## Test plan
- Reset: assert `Rst`=0 with random inputs -> all outputs 0, `in_ready`=0. Hold `in_valid`=1 in IDLE -> no `W_en`.
- Continuous load: `go` pulse, then `in_data`=k for k=0..31 with `in_valid` always 1 -> 32 writes (`W_addr`=k, `W_data`=k) on consecutive cycles. `done` coincides with `W_addr`=31, `chk`=496, then IDLE.
- Max checksum with backpressure: all bytes 0xFF, `in_valid` toggled 1/0 pseudo-randomly -> exactly 32 writes to addresses 0..31 in order, no write during gaps, `chk`=8160.
- Ignored `go`/extra data: `go` held high for the whole run and `in_valid` held after byte 32 -> no 33rd write, one `done` pulse. A second run starts the cycle after DONE with `chk` cleared to 0.
- Reset mid-load: assert `Rst` after 10 acceptances -> `W_en`=0 and `in_ready`=0 immediately. A restart with `in_data`=0xA5 x32 yields `chk`=5280 and writes 0..31.
- Reader cross-check: load 0,10,0,10,... then run the SAD datapath -> its `sum`=310 (31 differences of 10) and `chk`=160.
